// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with Start/Busy/Done handshake and optional iterative multiplier
// Optional feature macro: ALU_SEQ_MUL_EN builds the shift-add unsigned multiplier (FunSel 5'h10).
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_fun_sel,
    input  logic             i_wf,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_alu_out,
    output logic [WIDTH-1:0] o_alu_out_hi,
    output logic [3:0]       o_flags_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC
`ifdef ALU_SEQ_MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_fs;
    logic             r_wf;
    logic             r_cin;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_o;
    logic             w_legal;

    // Flag layout is {Z,C,N,O}; C/O default to their held values so ops that leave them alone need no special case.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_c     = r_flags[2];
        w_o     = r_flags[0];
        w_legal = 1'b1;
        case (r_fs)
            5'h00: w_res = r_a;
            5'h01: w_res = r_b;
            5'h02: w_res = ~r_a;
            5'h03: w_res = ~r_b;
            5'h04, 5'h05: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, (r_fs == 5'h05) & r_cin};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_o   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            5'h06: begin
                w_sum = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_o   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            5'h07: w_res = r_a & r_b;
            5'h08: w_res = r_a | r_b;
            5'h09: w_res = r_a ^ r_b;
            5'h0A: w_res = ~(r_a & r_b);
            5'h0B: begin w_res = {r_a[WIDTH-2:0], 1'b0};        w_c = r_a[WIDTH-1]; end
            5'h0C: begin w_res = {1'b0, r_a[WIDTH-1:1]};        w_c = r_a[0];       end
            5'h0D: begin w_res = {r_a[WIDTH-1], r_a[WIDTH-1:1]}; w_c = r_a[0];       end
            5'h0E: begin w_res = {r_a[WIDTH-2:0], r_cin};       w_c = r_a[WIDTH-1]; end
            5'h0F: begin w_res = {r_cin, r_a[WIDTH-1:1]};       w_c = r_a[0];       end
            default: w_legal = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_nxt;

    // Product register starts as {0, multiplier}; each step adds the multiplicand into the top half and shifts right.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign o_alu_out_hi = r_hi;
`else
    assign o_alu_out_hi = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_fs    <= '0;
            r_wf    <= 1'b0;
            r_cin   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_out   <= '0;
            r_flags <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_prod  <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_fs    <= i_fun_sel;
                        r_wf    <= i_wf;
                        r_cin   <= r_flags[2];
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                        r_prod  <= {{WIDTH{1'b0}}, i_b};
                        r_cnt   <= '0;
                        if (i_fun_sel == 5'h10) r_state <= S_MUL;
`endif
                    end
                end
                S_EXEC: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_legal) begin
                        r_out <= w_res;
`ifdef ALU_SEQ_MUL_EN
                        r_hi  <= '0;
`endif
                        if (r_wf) r_flags <= {w_res == '0, w_c, w_res[WIDTH-1], w_o};
                    end else begin
                        r_err <= 1'b1;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_out   <= w_prod_nxt[WIDTH-1:0];
                        r_hi    <= w_prod_nxt[2*WIDTH-1:WIDTH];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_wf) r_flags <= {w_prod_nxt == '0, w_prod_nxt[2*WIDTH-1:WIDTH] != '0,
                                              w_prod_nxt[2*WIDTH-1], r_flags[0]};
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_alu_out   = r_out;
    assign o_flags_out = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against a spec-level model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_a = '0;
    logic [15:0] i_b = '0;
    logic [4:0]  i_fs = '0;
    logic        i_wf = 1'b0;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_out, o_hi;
    logic [3:0]  o_flags;

    int tests = 0;
    int fails = 0;
    int lat;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_seq #(.WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(i_a), .i_b(i_b), .i_fun_sel(i_fs),
        .i_wf(i_wf), .i_start(i_start), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_alu_out(o_out), .o_alu_out_hi(o_hi), .o_flags_out(o_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model of one operation: plain integer arithmetic on the operands.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [4:0] fs,
                                  input logic cin, input logic wf, input logic [3:0] fin,
                                  output logic [15:0] r, output logic [15:0] hi,
                                  output logic [3:0] fo, output logic err);
        int unsigned s;
        logic [31:0] p;
        logic c, o;
        bit ismul;
        ismul = 1'b0; err = 1'b0; hi = '0; r = '0; p = '0;
        c = fin[2]; o = fin[0];
        case (fs)
            5'h00: r = a;
            5'h01: r = b;
            5'h02: r = ~a;
            5'h03: r = ~b;
            5'h04, 5'h05: begin
                s = 32'(a) + 32'(b) + ((fs == 5'h05) ? 32'(cin) : 32'd0);
                r = s[15:0];
                c = s > 32'd65535;
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'h06: begin
                r = a - b;
                c = a >= b;
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'h07: r = a & b;
            5'h08: r = a | b;
            5'h09: r = a ^ b;
            5'h0A: r = ~(a & b);
            5'h0B: begin r = a << 1; c = a[15]; end
            5'h0C: begin r = a >> 1; c = a[0]; end
            5'h0D: begin r = 16'($signed(a) >>> 1); c = a[0]; end
            5'h0E: begin r = (a << 1) | 16'(cin); c = a[15]; end
            5'h0F: begin r = (a >> 1) | (16'(cin) << 15); c = a[0]; end
            5'h10: begin
                if (MUL_EN) begin
                    p = 32'(a) * 32'(b);
                    r = p[15:0];
                    hi = p[31:16];
                    ismul = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            default: err = 1'b1;
        endcase
        fo = fin;
        if (!err && wf)
            fo = ismul ? {p == 32'd0, hi != 16'd0, hi[15], fin[0]} : {r == 16'd0, c, r[15], o};
    endfunction

    logic [15:0] m_out, m_hi, q_a, q_b, t_r, t_hi;
    logic [3:0]  m_flags, t_f;
    logic [4:0]  q_fs;
    logic        m_busy, m_done, m_err, q_wf, q_cin, t_e, was_busy;
    bit          pend;
    int          rem;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_out = '0; m_hi = '0; m_flags = '0;
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; pend = 1'b0; rem = 0;
        end else begin
            was_busy = m_busy;
            m_done = 1'b0;
            m_err = 1'b0;
            if (pend) begin
                rem--;
                if (rem == 0) begin
                    model(q_a, q_b, q_fs, q_cin, q_wf, m_flags, t_r, t_hi, t_f, t_e);
                    if (!t_e) begin m_out = t_r; m_hi = t_hi; end
                    m_flags = t_f;
                    m_err = t_e;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    pend = 1'b0;
                end
            end
            if (!was_busy && i_start) begin
                q_a = i_a; q_b = i_b; q_fs = i_fs; q_wf = i_wf; q_cin = m_flags[2];
                pend = 1'b1;
                m_busy = 1'b1;
                rem = (MUL_EN && i_fs == 5'h10) ? 16 : 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("busy", 32'(o_busy), 32'(m_busy));
            chk("done", 32'(o_done), 32'(m_done));
            chk("err", 32'(o_err), 32'(m_err));
            chk("alu_out", 32'(o_out), 32'(m_out));
            chk("alu_out_hi", 32'(o_hi), 32'(m_hi));
            chk("flags", 32'(o_flags), 32'(m_flags));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where Done is visible.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] fs,
                      input logic wf, input bit noise, output int l);
        i_a = a; i_b = b; i_fs = fs; i_wf = wf; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        l = 0;
        while (!o_done && l < 40) begin
            @(negedge clk);
            l++;
            i_start = noise && l >= 3 && l <= 8;
        end
        i_start = 1'b0;
        if (l >= 40) begin
            fails++;
            tests++;
            $display("FAIL timeout: no Done within 40 cycles, fs=0x%0h", fs);
        end
    endtask

    logic [15:0] v_a [8] = '{16'hFFFF, 16'h8001, 16'hA5A5, 16'h0F0F, 16'h8000, 16'h1234, 16'h7FFF, 16'h00FF};
    logic [15:0] v_b [8] = '{16'h0000, 16'h7FFF, 16'h5A5A, 16'hF0F0, 16'h8000, 16'h4321, 16'hFFFF, 16'h0101};

    initial begin
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_out", 32'(o_out), 32'd0);
        chk("rst_hi", 32'(o_hi), 32'd0);
        chk("rst_flags", 32'(o_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(16'h7FFF, 16'h0001, 5'h04, 1'b1, 1'b0, lat);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_out", 32'(o_out), 32'h8000);
        chk("add_flags", 32'(o_flags), 32'b0011);
        chk("model_add", 32'(m_out), 32'h8000);

        op(16'h0005, 16'h0005, 5'h06, 1'b1, 1'b0, lat);
        chk("sub_out", 32'(o_out), 32'h0000);
        chk("sub_flags", 32'(o_flags), 32'b1100);
        op(16'h0007, 16'h0005, 5'h06, 1'b0, 1'b0, lat);
        chk("sub_wf0_out", 32'(o_out), 32'h0002);
        chk("sub_wf0_flags", 32'(o_flags), 32'b1100);

        op(16'h0001, 16'h0001, 5'h04, 1'b1, 1'b0, lat);
        op(16'h8001, 16'h0000, 5'h0E, 1'b1, 1'b0, lat);
        chk("csl_out", 32'(o_out), 32'h0002);
        chk("csl_flags", 32'(o_flags), 32'b0100);
        op(16'h0002, 16'h0000, 5'h0F, 1'b1, 1'b0, lat);
        chk("csr_out", 32'(o_out), 32'h8001);
        chk("csr_flags", 32'(o_flags), 32'b0010);

        op(16'h1234, 16'h0100, 5'h10, 1'b1, 1'b1, lat);
        if (MUL_EN) begin
            chk("mul_lat", 32'(lat), 32'd16);
            chk("mul_lo", 32'(o_out), 32'h3400);
            chk("mul_hi", 32'(o_hi), 32'h0012);
            chk("mul_flags", 32'(o_flags), 32'b0100);
        end else begin
            chk("mul_off_err", 32'(o_err), 32'd1);
            chk("mul_off_out", 32'(o_out), 32'h8001);
        end

        op(16'h1111, 16'h2222, 5'h15, 1'b1, 1'b0, lat);
        chk("ill_err", 32'(o_err), 32'd1);
        chk("ill_out", 32'(o_out), MUL_EN ? 32'h3400 : 32'h8001);
        chk("ill_flags", 32'(o_flags), MUL_EN ? 32'b0100 : 32'b0010);

        for (int i = 0; i < 8; i++)
            for (int f = 0; f < 16; f++)
                op(v_a[i], v_b[i], 5'(f), 1'((i + f) % 3 != 0), 1'b0, lat);
        if (MUL_EN) op(16'hFFFF, 16'hFFFF, 5'h10, 1'b1, 1'b0, lat);
        if (MUL_EN) op(16'h0000, 16'hBEEF, 5'h10, 1'b1, 1'b0, lat);

        op(16'h00F0, 16'h000F, 5'h08, 1'b1, 1'b0, lat);
        i_a = 16'h4321; i_b = 16'h0003; i_fs = MUL_EN ? 5'h10 : 5'h04; i_wf = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (MUL_EN) repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", 32'(o_out), 32'd0);
        chk("abort_hi", 32'(o_hi), 32'd0);
        chk("abort_flags", 32'(o_flags), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        op(16'h0003, 16'h0004, 5'h04, 1'b1, 1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_out", 32'(o_out), 32'h0007);
        chk("post_rst_flags", 32'(o_flags), 32'b0000);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
